sprite_sched: RTL and testbench

SPRITE_SCHED -- requirements
Module: sprite_sched

---
 rtl/sprite_sched.sv | 170 +++++++++++++++++
 tb/tb_sprite_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_sched.sv
// Sprite scheduler: walks the sprite table once per frame and hands each eligible entry to the renderer.
// Define SPRITE_SCHED_CLIP_EN to skip sprites that would extend past the screen edge.
module sprite_sched #(
  parameter int NSPR       = 8,
  parameter int CORDW      = 10,
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    wr_en,
  input  logic [$clog2(NSPR)-1:0] wr_idx,
  input  logic [CORDW-1:0]        wr_x,
  input  logic [CORDW-1:0]        wr_y,
  input  logic                    wr_valid,
  output logic                    spr_start,
  output logic [CORDW-1:0]        spr_x,
  output logic [CORDW-1:0]        spr_y,
  input  logic                    spr_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic [$clog2(NSPR):0]   drawn_cnt,
  output logic                    overrun
);

  localparam int IW   = $clog2(NSPR);
  localparam int CNTW = IW + 1;
  localparam int CW1  = CORDW + 1;

`ifdef SPRITE_SCHED_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [CORDW:0] SW = CW1'(SPR_WIDTH);
  localparam logic [CORDW:0] SH = CW1'(SPR_HEIGHT);
  localparam logic [CORDW:0] HR = CW1'(H_RES);
  localparam logic [CORDW:0] VR = CW1'(V_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   drawn_q, drawn_d;
  logic [CORDW-1:0]  sx_q, sx_d;
  logic [CORDW-1:0]  sy_q, sy_d;
  logic              overrun_q, overrun_d;

  logic [NSPR-1:0]   valid_q;
  logic [CORDW-1:0]  tx_q [NSPR];
  logic [CORDW-1:0]  ty_q [NSPR];

  logic [CORDW-1:0]  cur_x, cur_y;
  logic [CORDW:0]    x_end, y_end;
  logic              elig, last;

  // Writes land at the clock edge, so a same-cycle SCAN read still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tx_q[wr_idx] <= wr_x;
      ty_q[wr_idx] <= wr_y;
    end
  end

  assign cur_x = tx_q[idx_q];
  assign cur_y = ty_q[idx_q];
  // One extra bit keeps x+width from wrapping near the top of the coordinate range.
  assign x_end = {1'b0, cur_x} + SW;
  assign y_end = {1'b0, cur_y} + SH;
  assign elig  = valid_q[idx_q] && (!CLIP_EN || ((x_end <= HR) && (y_end <= VR)));
  assign last  = (idx_q == IW'(NSPR - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    drawn_d   = drawn_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    overrun_d = overrun_q | (frame_start && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (elig) begin
          state_d = S_LAUNCH;
          sx_d    = cur_x;
          sy_d    = cur_y;
        end else if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_q + CNTW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spr_done) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        drawn_d = cnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      drawn_q   <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      drawn_q   <= drawn_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      overrun_q <= overrun_d;
    end
  end

  assign spr_start  = (state_q == S_LAUNCH);
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign spr_x      = sx_q;
  assign spr_y      = sy_q;
  assign drawn_cnt  = drawn_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_sched.sv
// Bench for sprite_sched: directed scenarios plus randomized frames against a table-level model.
// Latency: pass length checked as NSPR+1 plus launch and renderer cycles per dispatch.
// Backpressure: renderer modelled by delayed spr_done pulses with stray pulses mixed in.
module tb_sprite_sched;
    localparam int NSPR  = 8;
    localparam int CORDW = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [CORDW-1:0] wr_x, wr_y;
    logic             wr_valid;
    logic             spr_start;
    logic [CORDW-1:0] spr_x, spr_y;
    logic             spr_done;
    logic             busy;
    logic             frame_done;
    logic [3:0]       drawn_cnt;
    logic             overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int m_v [NSPR];
    int m_x [NSPR];
    int m_y [NSPR];

    sprite_sched dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_valid(wr_valid),
        .spr_start(spr_start), .spr_x(spr_x), .spr_y(spr_y), .spr_done(spr_done),
        .busy(busy), .frame_done(frame_done), .drawn_cnt(drawn_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit elig(int i);
`ifdef SPRITE_SCHED_CLIP_EN
        return (m_v[i] != 0) && (m_x[i] + 8 <= 800) && (m_y[i] + 8 <= 480);
`else
        return (m_v[i] != 0);
`endif
    endfunction

    task automatic wr(input int i, input int x, input int y, input int v);
        wr_en    = 1'b1;
        wr_idx   = 3'(i);
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_valid = (v != 0);
        step();
        wr_en = 1'b0;
        m_v[i] = v;
        m_x[i] = x;
        m_y[i] = y;
    endtask

    task automatic clear_model_valid();
        for (int i = 0; i < NSPR; i++) m_v[i] = 0;
    endtask

    // Pass length: one cycle per entry scanned, plus launch and renderer time per dispatch, plus DONE.
    task automatic run_frame(input int dmin, input int dmax, input bit noise,
                             input int fs2_at, input int wr_at, input int wr_i, input int wr_xv);
        int exp_x[$], exp_y[$], got_x[$], got_y[$];
        int k, done_at, dsum, d, nmin;
        bit outst, busy_ok, seen_done;
        for (int i = 0; i < NSPR; i++) begin
            if (elig(i)) begin
                exp_x.push_back(m_x[i]);
                exp_y.push_back(m_y[i]);
            end
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        k = 1; outst = 0; dsum = 0; busy_ok = 1; seen_done = 0; done_at = 0;
        while (k < 3000) begin
            spr_done    = 1'b0;
            frame_start = 1'b0;
            wr_en       = 1'b0;
            if (busy !== 1'b1) busy_ok = 0;
            if (spr_start === 1'b1) begin
                got_x.push_back(int'(spr_x));
                got_y.push_back(int'(spr_y));
                d = int'($urandom_range(dmax, dmin));
                dsum += d;
                done_at = k + d;
                outst = 1;
                if (noise && ($urandom_range(1, 0) == 1)) spr_done = 1'b1;
            end else if (outst && k == done_at) begin
                spr_done = 1'b1;
                outst = 0;
            end else if (!outst && noise && ($urandom_range(3, 0) == 0)) begin
                spr_done = 1'b1;
            end
            if (k == fs2_at) frame_start = 1'b1;
            if (k == wr_at) begin
                wr_en    = 1'b1;
                wr_idx   = 3'(wr_i);
                wr_x     = 10'(wr_xv);
                wr_y     = 10'(m_y[wr_i]);
                wr_valid = (m_v[wr_i] != 0);
            end
            if (frame_done === 1'b1) begin
                seen_done = 1;
                break;
            end
            step();
            k++;
        end
        spr_done = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
        chk("frame_done_seen", seen_done, 1'b1);
        chk("frame_done_cycle", k, NSPR + 1 + exp_x.size() + dsum);
        chk("busy_during_pass", busy_ok, 1'b1);
        chk("dispatch_count", got_x.size(), exp_x.size());
        nmin = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < nmin; i++) begin
            chk("dispatch_x", got_x[i], exp_x[i]);
            chk("dispatch_y", got_y[i], exp_y[i]);
        end
        step();
        chk("drawn_cnt", int'(drawn_cnt), exp_x.size());
        chk("idle_after_pass", busy, 1'b0);
        if (exp_x.size() > 0) begin
            chk("spr_x_hold", int'(spr_x), exp_x[exp_x.size()-1]);
            chk("spr_y_hold", int'(spr_y), exp_y[exp_y.size()-1]);
        end
        if (wr_at > 0) m_x[wr_i] = wr_xv;
    endtask

    initial begin
        bit quiet_ok;
        rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
        wr_x = '0; wr_y = '0; wr_valid = 1'b0; spr_done = 1'b0;
        clear_model_valid();
        for (int i = 0; i < NSPR; i++) begin m_x[i] = 0; m_y[i] = 0; end
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_spr_start", spr_start, 1'b0);
        chk("rst_spr_x", int'(spr_x), 0);
        chk("rst_spr_y", int'(spr_y), 0);
        chk("rst_drawn_cnt", int'(drawn_cnt), 0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        step();

        // Empty table: frame_done NSPR+1 cycles after frame_start.
        run_frame(1, 1, 0, 0, 0, 0, 0);

        // Two valid entries, renderer takes 64 cycles.
        wr(0, 10, 20, 1);
        wr(3, 100, 200, 1);
        run_frame(64, 64, 0, 0, 0, 0, 0);

        // frame_start arriving in WAIT sets overrun and is otherwise ignored.
        chk("overrun_before", overrun, 1'b0);
        run_frame(64, 64, 0, 3, 0, 0, 0);
        chk("overrun_set", overrun, 1'b1);
        quiet_ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (spr_start !== 1'b0 || busy !== 1'b0) quiet_ok = 0;
            step();
        end
        chk("no_extra_pass", quiet_ok, 1'b1);

        // Reset while the renderer is busy.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step(); step(); step();
        chk("in_wait_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_done", frame_done, 1'b0);
        chk("midrst_spr_x", int'(spr_x), 0);
        chk("midrst_overrun", overrun, 1'b0);
        step();
        rst = 1'b0;
        clear_model_valid();
        quiet_ok = 1;
        for (int i = 0; i < 3; i++) begin
            if (frame_done !== 1'b0) quiet_ok = 0;
            step();
        end
        chk("no_done_after_rst", quiet_ok, 1'b1);
        run_frame(2, 2, 0, 0, 0, 0, 0);

        // Write to entry 5 on the same edge that SCAN evaluates it.
        wr(5, 30, 7, 1);
        run_frame(3, 3, 0, 0, 6, 5, 50);
        chk("late_write_old_x", int'(spr_x), 30);
        run_frame(3, 3, 0, 0, 0, 0, 0);
        chk("late_write_new_x", int'(spr_x), 50);

        // Screen-edge cases.
        wr(5, 0, 0, 0);
        wr(1, 795, 0, 1);
        wr(2, 792, 472, 1);
        run_frame(2, 2, 0, 0, 0, 0, 0);
`ifdef SPRITE_SCHED_CLIP_EN
        chk("edge_drawn", int'(drawn_cnt), 1);
`else
        chk("edge_drawn", int'(drawn_cnt), 2);
`endif

        // Random tables, renderer delays and stray spr_done pulses.
        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = int'($urandom_range(3, 0));
            for (int w = 0; w < nw; w++) begin
                int xi, yi;
                xi = ($urandom_range(1, 0) == 1) ? int'($urandom_range(799, 780)) : int'($urandom_range(1023, 0));
                yi = ($urandom_range(1, 0) == 1) ? int'($urandom_range(479, 465)) : int'($urandom_range(1023, 0));
                wr(int'($urandom_range(NSPR-1, 0)), xi, yi, int'($urandom_range(1, 0)));
            end
            run_frame(1, 6, 1, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
